uart_autobaud_meter: RTL

- Parametrised automatic baud-rate measurement for the RS232 receive path.
- Observes the raw RX line and times NB_MEAS consecutive start/data low pulses of a 0x55 sync character, in prescaled clk_ref ticks.
- Averages the pulses with rounding and presents a locked bit-period divisor to the UART RX/TX cores.
- Supports rejection of short glitches, an error exit on overlong pulses, and re-learning on request.

---
 rtl/uart_autobaud_pkg.sv | 25 ++
 rtl/uart_autobaud_meter_if.sv | 17 +
 rtl/uart_rx_edge_sync.sv | 44 ++++
 rtl/uart_autobaud_meter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/uart_autobaud_pkg.sv
// Shared types and helpers for the UART auto-baud meter.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LOW,
    S_HIGH,
    S_DONE,
    S_LOCK
  } state_t;

  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_NB_MEAS = 4;
  localparam int unsigned MEAS_SH     = log2(DEF_NB_MEAS);
  localparam int unsigned ACC_W       = DEF_CNT_W + MEAS_SH;

endpackage

// File: rtl/uart_autobaud_meter_if.sv
// Control/result bundle between the auto-baud meter and the UART cores.
interface uart_autobaud_meter_if #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PRESCALE_W = 4
);
  logic [PRESCALE_W-1:0] prescale;
  logic                  relearn;
  logic [CNT_W-1:0]      baud_div;
  logic                  baud_valid;
  logic                  meas_err;
  logic                  busy;

  modport master (output prescale, relearn,
                  input  baud_div, baud_valid, meas_err, busy);
  modport slave  (input  prescale, relearn,
                  output baud_div, baud_valid, meas_err, busy);
endinterface

// File: rtl/uart_rx_edge_sync.sv
// RX synchroniser and rise/fall pulse generation.
// UART_AUTOBAUD_GLITCH_FILTER_EN adds a 3-sample majority filter (1 cycle latency).
module uart_rx_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic rx_i,
  output logic rx_lvl,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   lvl_q;

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) hist_q <= '1;
    else     hist_q <= {hist_q[0], rx_s};
  end

  assign rx_lvl = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign rx_lvl = rx_s;
`endif

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) lvl_q <= 1'b1;
    else     lvl_q <= rx_lvl;
  end

  assign rise = rx_lvl & ~lvl_q;
  assign fall = ~rx_lvl & lvl_q;
endmodule

// File: rtl/uart_autobaud_meter.sv
// Auto-baud meter: times NB_MEAS low pulses of a 0x55 sync char and locks a rounded mean divisor.
// Optional UART_AUTOBAUD_GLITCH_FILTER_EN majority filter lives in uart_rx_edge_sync.
module uart_autobaud_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned PRESCALE_W  = 4,
  parameter int unsigned NB_MEAS     = 4,
  parameter int unsigned MIN_CNT     = 4,
  parameter int unsigned IDLE_TICKS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_ref,
  input  logic                  rst,
  input  logic                  rx_i,
  uart_autobaud_meter_if.slave  bus
);
  import uart_autobaud_pkg::*;

  localparam int unsigned SHIFT     = log2(NB_MEAS);
  localparam int unsigned ACC_WIDTH = CNT_W + SHIFT;
  localparam int unsigned IDX_W     = (SHIFT == 0) ? 1 : SHIFT;

  localparam logic [CNT_W-1:0]     MIN_C    = CNT_W'(MIN_CNT);
  localparam logic [CNT_W-1:0]     IDLE_C   = CNT_W'(IDLE_TICKS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NB_MEAS - 1);
  localparam logic [ACC_WIDTH-1:0] HALF     = ACC_WIDTH'(NB_MEAS / 2);

  logic                  rx_lvl, rise, fall;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc, meas;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, acc_rnd;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_lim_q;
  logic [CNT_W-1:0]      div_q;
  logic                  err_q, err_d, div_ld;
  logic                  tick, cnt_sat, restart;

  uart_rx_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk_ref (clk_ref),
    .rst     (rst),
    .rx_i    (rx_i),
    .rx_lvl  (rx_lvl),
    .rise    (rise),
    .fall    (fall)
  );

  assign tick    = (pre_cnt_q == pre_lim_q);
  assign cnt_sat = (cnt_q == '1);
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + 1'b1;
  // Tick on the closing edge's own cycle is part of the pulse just ended.
  assign meas    = tick ? cnt_inc : cnt_q;
  assign acc_rnd = acc_q + HALF;
  assign restart = rise | fall | bus.relearn | (state_d != state_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    div_ld  = 1'b0;
    if (bus.relearn) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rx_lvl) cnt_d = '0;
          else if (cnt_q == IDLE_C) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end else if (tick) cnt_d = cnt_inc;
        end
        S_ARMED: begin
          if (fall) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end
        end
        S_LOW, S_HIGH: begin
          if (cnt_sat) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            idx_d   = '0;
          end else if (state_q == S_HIGH && fall) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end else if (state_q == S_LOW && rise) begin
            cnt_d = '0;
            if (meas < MIN_C) state_d = S_ARMED;
            else begin
              acc_d = acc_q + ACC_WIDTH'(meas);
              if (idx_q == LAST_IDX) state_d = S_DONE;
              else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_HIGH;
              end
            end
          end else if (tick) cnt_d = cnt_inc;
        end
        S_DONE: begin
          div_ld  = 1'b1;
          state_d = S_LOCK;
          cnt_d   = '0;
        end
        S_LOCK: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      div_q     <= '0;
      pre_cnt_q <= '0;
      pre_lim_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      if (div_ld) div_q <= CNT_W'(acc_rnd >> SHIFT);
      // A new prescale value is only picked up when the prescaler restarts.
      if (restart) begin
        pre_cnt_q <= '0;
        pre_lim_q <= bus.prescale;
      end else if (tick) pre_cnt_q <= '0;
      else               pre_cnt_q <= pre_cnt_q + 1'b1;
    end
  end

  assign bus.baud_div   = div_q;
  assign bus.baud_valid = (state_q == S_LOCK);
  assign bus.meas_err   = err_q;
  assign bus.busy       = (state_q == S_ARMED) || (state_q == S_LOW) || (state_q == S_HIGH);
endmodule
